lcd_frame_port_arbiter: RTL
===========================

# lcd_frame_port_arbiter

Shares one single-port synchronous frame RAM (24-bit RGB, 1-cycle read latency) between the LCD display read path and a pixel-write requester such as a drawing engine. The display path has absolute priority: every cycle the LCD timing controller asserts its read enable, the RAM is read at the next sequential frame address, and the RGB result is presented the following cycle. Writes queue in a small FIFO and drain into RAM only during cycles the display is not reading, such as horizontal and vertical blanking.

## Interface
- H_ACTIVE, 800, active pixels per line
- V_ACTIVE, 480, active lines per frame
- ADDR_W, 19, frame RAM address width; must satisfy 2^ADDR_W ≥ H_ACTIVE·V_ACTIVE
- WFIFO_DEPTH, 4, write FIFO entries (power of two, ≥ 2)

Ports:
- iCLK  in  1  display pixel clock; the only clock
- iRST  in  1  reset, asynchronous, active-high
- iREAD_EN  in  1  display read request, one pixel per cycle while high
- iVD  in  1  vertical sync, active-low
- oRed / oGreen / oBlue  out  8 each  pixel data to the timing controller
- iWR_VALID  in  1  write request
- iWR_ADDR  in  ADDR_W  write pixel address
- iWR_DATA  in  24  write pixel {R,G,B}
- oWR_READY  out  1  write FIFO can accept
- oMEM_ADDR  out  ADDR_W  RAM address
- oMEM_WE  out  1  RAM write strobe
- oMEM_WDATA  out  24  RAM write data
- iMEM_RDATA  in  24  RAM read data, valid one cycle after a read cycle
- oWR_OVERRUN  out  1  sticky: iWR_VALID was high while oWR_READY was low

## Operation
- **Read pointer `rd_addr` (ADDR_W bits):**
  - Held at 0 in any cycle where iVD=0.
  - Otherwise increments by 1 on each cycle with iREAD_EN=1.
  - Wraps from H_ACTIVE·V_ACTIVE−1 to 0.
  - If iVD=0 and iREAD_EN=1 in the same cycle, the read uses the current rd_addr and rd_addr then becomes 0.
- **Arbitration:** decided combinationally each cycle; two grants.
  - READ, when iREAD_EN=1:
    - oMEM_ADDR=rd_addr, oMEM_WE=0.
    - Registered flag `rd_pend` is set for the next cycle.
  - WRITE, when iREAD_EN=0 and the FIFO is not empty:
    - oMEM_ADDR=head.addr, oMEM_WDATA=head.data, oMEM_WE=1.
    - The head entry is popped at the clock edge.
  - IDLE, otherwise:
    - oMEM_WE=0, oMEM_ADDR=rd_addr.
- **Pixel output:**
  - When rd_pend=1: {oRed,oGreen,oBlue}=iMEM_RDATA (combinational pass-through).
  - When rd_pend=0: all three are 0.
- **Write FIFO:**
  - Holds WFIFO_DEPTH entries, each an {addr,data} pair.
  - oWR_READY = !full.
  - An entry is pushed when iWR_VALID & oWR_READY.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - When full, a push is refused even if a pop occurs that cycle; oWR_READY depends only on registered occupancy.
- **Overrun:**
  - oWR_OVERRUN sets when iWR_VALID=1 and oWR_READY=0.
  - It clears only on reset.
- **Write ordering:**
  - FIFO order is preserved.
  - A write to the address being read in the same cycle is not visible to that read.
- **Reset (iRST=1, asynchronous):**
  - FIFO is emptied, rd_addr=0, rd_pend=0, oWR_OVERRUN=0.
  - Consequently oRed/oGreen/oBlue=0, oMEM_WE=0, oMEM_ADDR=0.
  - oWR_READY=0 while iRST is high and 1 on the first cycle after release.
  - Writes queued before reset are discarded.

## Timing
- Read latency is exactly 1 cycle: iREAD_EN high in cycle N means pixel data is on oRed/oGreen/oBlue in cycle N+1. This matches the timing controller, whose read enable leads its display window by one cycle.
- A write drains at the earliest in the cycle after the push, provided iREAD_EN=0 in that cycle.
- Worst case, a write stalls for an entire active run (H_ACTIVE cycles).
- With the standard 1056-cycle line there are 256 free cycles per line, so the sustained write rate is ≤ 256 pixels per line.
- oMEM_ADDR, oMEM_WE and oMEM_WDATA are combinational from registered state and iREAD_EN; iREAD_EN must be a registered-output-derived signal.

## Test plan
- **Reset:**
  - Stimulus: assert iRST mid-line with 3 FIFO entries queued, then release.
  - Required: oMEM_WE=0, RGB=0, oWR_READY=0 during reset; after release, oWR_READY=1, no queued write appears on the RAM port, and the first read uses address 0.
- **Sequential read:**
  - Stimulus: iVD=1, iREAD_EN high for 800 cycles; the RAM model returns data = address.
  - Required: oMEM_ADDR goes 0…799, and RGB in cycle N+1 equals N.
  - Stimulus: a second 800-cycle burst.
  - Required: addresses continue 800…1599.
- **Frame wrap and vsync:**
  - Stimulus: run 384000 reads.
  - Required: read 384000 uses address 0 again.
  - Stimulus: separately, pulse iVD=0 for 1 cycle mid-frame at rd_addr=1234.
  - Required: the next read uses address 0.
- **Write drain in blanking:**
  - Stimulus: push 4 writes (addr 10..13, data 0xAA0000+i) while iREAD_EN=1.
  - Required: oWR_READY falls after the 4th push; nothing is written while iREAD_EN=1.
  - Stimulus: drop iREAD_EN.
  - Required: 4 consecutive oMEM_WE cycles with addresses 10..13, in order.
- **Priority collision:**
  - Stimulus: FIFO non-empty and iREAD_EN toggling 1/0 each cycle.
  - Required: oMEM_WE only in the cycles where iREAD_EN=0; read latency still 1.
- **Overrun:**
  - Stimulus: with the FIFO full, hold iWR_VALID=1 for 1 cycle.
  - Required: the entry is not stored, and oWR_OVERRUN=1 and remains set until iRST.

Source files
------------

// File: rtl/lcd_frame_port_arbiter.sv
// lcd_frame_port_arbiter
// Shares one single-port synchronous frame RAM (24-bit RGB, 1-cycle read
// latency) between the LCD display read path and a pixel-write requester.
// The display read always wins. Writes wait in a small FIFO and drain only in
// cycles where the display is not reading, for example during blanking.
//
// Ports
//   iCLK, iRST            pixel clock; asynchronous active-high reset
//   iREAD_EN              display read request, one pixel per cycle
//   iVD                   vertical sync, active-low; restarts the frame address
//   oRed/oGreen/oBlue     pixel data, one cycle after the read
//   iWR_VALID/ADDR/DATA   pixel write request
//   oWR_READY             write FIFO can accept an entry
//   oMEM_ADDR/WE/WDATA    frame RAM port
//   iMEM_RDATA            frame RAM read data, one cycle after a read
//   oWR_OVERRUN           sticky flag: a write was offered while not ready
module lcd_frame_port_arbiter #(
   parameter int H_ACTIVE    = 800,
   parameter int V_ACTIVE    = 480,
   parameter int ADDR_W      = 19,
   parameter int WFIFO_DEPTH = 4
) (
   input  logic              iCLK,
   input  logic              iRST,
   input  logic              iREAD_EN,
   input  logic              iVD,
   output logic [7:0]        oRed,
   output logic [7:0]        oGreen,
   output logic [7:0]        oBlue,
   input  logic              iWR_VALID,
   input  logic [ADDR_W-1:0] iWR_ADDR,
   input  logic [23:0]       iWR_DATA,
   output logic              oWR_READY,
   output logic [ADDR_W-1:0] oMEM_ADDR,
   output logic              oMEM_WE,
   output logic [23:0]       oMEM_WDATA,
   input  logic [23:0]       iMEM_RDATA,
   output logic              oWR_OVERRUN
);

   localparam int PTR_W = $clog2(WFIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(WFIFO_DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

   logic [ADDR_W-1:0] r_rd_addr;
   logic              r_rd_pend;
   logic              r_overrun;
   logic [PTR_W-1:0]  r_wptr;
   logic [PTR_W-1:0]  r_rptr;
   logic [CNT_W-1:0]  r_count;
   logic [ADDR_W-1:0] r_fifo_addr [WFIFO_DEPTH];
   logic [23:0]       r_fifo_data [WFIFO_DEPTH];

   logic w_full;
   logic w_empty;
   logic w_ready;
   logic w_push;
   logic w_pop;

   assign w_full  = (r_count == FULL_CNT);
   assign w_empty = (r_count == '0);
   // Ready looks only at registered occupancy, so a full FIFO refuses a push
   // even in a cycle where it is also draining.
   assign w_ready = ~w_full & ~iRST;
   assign w_push  = iWR_VALID & w_ready;
   // Display read has absolute priority over the write drain.
   assign w_pop   = ~iREAD_EN & ~w_empty;

   assign oWR_READY   = w_ready;
   assign oWR_OVERRUN = r_overrun;

   always_comb begin
      oMEM_ADDR  = r_rd_addr;
      oMEM_WE    = 1'b0;
      oMEM_WDATA = '0;
      if (w_pop) begin
         oMEM_ADDR  = r_fifo_addr[r_rptr];
         oMEM_WE    = 1'b1;
         oMEM_WDATA = r_fifo_data[r_rptr];
      end
   end

   always_comb begin
      {oRed, oGreen, oBlue} = 24'h0;
      if (r_rd_pend) begin
         {oRed, oGreen, oBlue} = iMEM_RDATA;
      end
   end

   // Read pointer: a read in a vsync cycle still uses the current address,
   // and the pointer then restarts at 0.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         r_rd_addr <= '0;
         r_rd_pend <= 1'b0;
      end else begin
         r_rd_pend <= iREAD_EN;
         if (!iVD) begin
            r_rd_addr <= '0;
         end else if (iREAD_EN) begin
            if (r_rd_addr == LAST_ADDR) begin
               r_rd_addr <= '0;
            end else begin
               r_rd_addr <= r_rd_addr + ADDR_W'(1);
            end
         end
      end
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_count   <= '0;
         r_overrun <= 1'b0;
      end else begin
         if (iWR_VALID && !w_ready) begin
            r_overrun <= 1'b1;
         end
         if (w_push) begin
            r_wptr <= r_wptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset; occupancy alone decides what is valid.
   always_ff @(posedge iCLK) begin
      if (w_push) begin
         r_fifo_addr[r_wptr] <= iWR_ADDR;
         r_fifo_data[r_wptr] <= iWR_DATA;
      end
   end

endmodule
